// File: rtl/ctrl_relogio.sv
// Digital clock controller: 1 Hz divider, seconds counter, RUN/SET_HOUR/SET_MIN
// mode FSM and the enable/increment/blink signals for the minute and hour counters.
module ctrl_relogio #(
  parameter int DIV = 50_000_000
) (
  input  logic       ctrl_clock,
  input  logic       ctrl_reset,
  input  logic       ctrl_btn_modo,
  input  logic       ctrl_btn_inc,
  input  logic       ctrl_incrementa_hora,
  output logic       ctrl_enable_m,
  output logic       ctrl_incremento_m,
  output logic       ctrl_enable_h,
  output logic       ctrl_incremento_h,
  output logic [3:0] ctrl_seg_lsd,
  output logic [2:0] ctrl_seg_msd,
  output logic       ctrl_blink_m,
  output logic       ctrl_blink_h
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_t;

  // BCD seconds step {msd, lsd}: x9 -> (x+1)0, 59 -> 00
  function automatic logic [6:0] sec_advance(input logic [2:0] msd, input logic [3:0] lsd);
    if (lsd == 4'd9) begin
      if (msd == 3'd5) return 7'd0;
      return {msd + 3'd1, 4'd0};
    end
    return {msd, lsd + 4'd1};
  endfunction

  mode_t            state_p1, state_p0;
  logic [CNT_W-1:0] cnt_p1, cnt_p0;
  logic [3:0]       lsd_p1;
  logic [2:0]       msd_p1;
  logic [6:0]       sec_p0;
  logic             phase_p1, phase_p0;
  logic             hist_modo_p1, hist_inc_p1;
  logic             inc_m_p1, inc_m_p0;
  logic             inc_h_p1, inc_h_p0;
  logic             en_m_p1, en_m_p0;
  logic             en_h_p1, en_h_p0;
  logic             blink_m_p1, blink_m_p0;
  logic             blink_h_p1, blink_h_p0;

  logic tick;
  logic press_modo;
  logic press_inc;
  logic sec_is_59;

  assign tick       = (cnt_p1 == CNT_MAX);
  assign press_modo = ctrl_btn_modo & ~hist_modo_p1;
  assign press_inc  = ctrl_btn_inc & ~hist_inc_p1;
  assign sec_is_59  = (msd_p1 == 3'd5) && (lsd_p1 == 4'd9);

  // Stage p0: next-state and next-output decode
  always_comb begin
    state_p0 = state_p1;
    cnt_p0   = tick ? '0 : cnt_p1 + CNT_W'(1);
    sec_p0   = {msd_p1, lsd_p1};
    phase_p0 = phase_p1;
    inc_m_p0 = 1'b0;
    inc_h_p0 = 1'b0;

    if (press_modo) begin
      // A mode change overrides a coincident tick or inc press
      cnt_p0   = '0;
      sec_p0   = '0;
      phase_p0 = 1'b0;
      unique case (state_p1)
        RUN:      state_p0 = SET_HOUR;
        SET_HOUR: state_p0 = SET_MIN;
        default:  state_p0 = RUN;
      endcase
    end else begin
      unique case (state_p1)
        RUN: begin
          phase_p0 = 1'b0;
          if (tick) begin
            sec_p0 = sec_advance(msd_p1, lsd_p1);
            if (sec_is_59) begin
              inc_m_p0 = 1'b1;
              inc_h_p0 = ctrl_incrementa_hora;
            end
          end
        end
        SET_HOUR: begin
          sec_p0   = '0;
          inc_h_p0 = press_inc;
          if (tick) phase_p0 = ~phase_p1;
        end
        SET_MIN: begin
          sec_p0   = '0;
          inc_m_p0 = press_inc;
          if (tick) phase_p0 = ~phase_p1;
        end
        default: begin
          state_p0 = RUN;
          cnt_p0   = '0;
          sec_p0   = '0;
          phase_p0 = 1'b0;
        end
      endcase
    end

    en_m_p0    = (state_p0 != SET_HOUR);
    en_h_p0    = (state_p0 != SET_MIN);
    blink_h_p0 = (state_p0 == SET_HOUR) & phase_p0;
    blink_m_p0 = (state_p0 == SET_MIN) & phase_p0;
  end

  // Stage p1: registered state and outputs
  always_ff @(posedge ctrl_clock) begin
    if (ctrl_reset) begin
      state_p1     <= RUN;
      cnt_p1       <= '0;
      lsd_p1       <= '0;
      msd_p1       <= '0;
      phase_p1     <= 1'b0;
      hist_modo_p1 <= 1'b0;
      hist_inc_p1  <= 1'b0;
      inc_m_p1     <= 1'b0;
      inc_h_p1     <= 1'b0;
      en_m_p1      <= 1'b1;
      en_h_p1      <= 1'b1;
      blink_m_p1   <= 1'b0;
      blink_h_p1   <= 1'b0;
    end else begin
      state_p1     <= state_p0;
      cnt_p1       <= cnt_p0;
      lsd_p1       <= sec_p0[3:0];
      msd_p1       <= sec_p0[6:4];
      phase_p1     <= phase_p0;
      hist_modo_p1 <= ctrl_btn_modo;
      hist_inc_p1  <= ctrl_btn_inc;
      inc_m_p1     <= inc_m_p0;
      inc_h_p1     <= inc_h_p0;
      en_m_p1      <= en_m_p0;
      en_h_p1      <= en_h_p0;
      blink_m_p1   <= blink_m_p0;
      blink_h_p1   <= blink_h_p0;
    end
  end

  assign ctrl_enable_m     = en_m_p1;
  assign ctrl_enable_h     = en_h_p1;
  assign ctrl_incremento_m = inc_m_p1;
  assign ctrl_incremento_h = inc_h_p1;
  assign ctrl_seg_lsd      = lsd_p1;
  assign ctrl_seg_msd      = msd_p1;
  assign ctrl_blink_m      = blink_m_p1;
  assign ctrl_blink_h      = blink_h_p1;

endmodule

// File: tb/tb_ctrl_relogio.sv
// Scoreboard bench for ctrl_relogio with DIV=4: a behavioural model queues the
// expected outputs per driven cycle; directed sequences add event-count checks.
module tb_ctrl_relogio;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bm  = 1'b0;
  logic       bi  = 1'b0;
  logic       ih  = 1'b0;
  logic       en_m, inc_m, en_h, inc_h, blk_m, blk_h;
  logic [3:0] lsd;
  logic [2:0] msd;

  always #5 clk = ~clk;

  ctrl_relogio #(.DIV(DIV)) dut (
    .ctrl_clock           (clk),
    .ctrl_reset           (rst),
    .ctrl_btn_modo        (bm),
    .ctrl_btn_inc         (bi),
    .ctrl_incrementa_hora (ih),
    .ctrl_enable_m        (en_m),
    .ctrl_incremento_m    (inc_m),
    .ctrl_enable_h        (en_h),
    .ctrl_incremento_h    (inc_h),
    .ctrl_seg_lsd         (lsd),
    .ctrl_seg_msd         (msd),
    .ctrl_blink_m         (blk_m),
    .ctrl_blink_h         (blk_h)
  );

  // {inc_m, inc_h, en_m, en_h, blink_m, blink_h, msd, lsd}
  typedef logic [12:0] vec_t;
  vec_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int m_state = 0;  // 0 RUN, 1 SET_HOUR, 2 SET_MIN
  int m_cnt   = 0;
  int m_sec   = 0;
  bit m_phase = 1'b0;
  bit m_hm    = 1'b0;
  bit m_hi    = 1'b0;

  int cnt_im, cnt_ih, cnt_both, cnt_bm, cnt_tog;
  logic last_bh;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, act, exp);
    end
  endtask

  task automatic model(input logic r, input logic mo, input logic in, input logic hr);
    bit pm, pi, tk, eim, eih;
    vec_t e;
    eim = 1'b0;
    eih = 1'b0;
    if (r) begin
      m_state = 0; m_cnt = 0; m_sec = 0; m_phase = 1'b0; m_hm = 1'b0; m_hi = 1'b0;
    end else begin
      pm = mo && !m_hm;
      pi = in && !m_hi;
      tk = (m_cnt == DIV - 1);
      if (pm) begin
        m_state = (m_state + 1) % 3;
        m_cnt   = 0;
        m_sec   = 0;
        m_phase = 1'b0;
      end else begin
        m_cnt = tk ? 0 : m_cnt + 1;
        if (m_state == 0) begin
          if (tk) begin
            if (m_sec == 59) begin
              eim = 1'b1;
              eih = hr;
            end
            m_sec = (m_sec + 1) % 60;
          end
        end else begin
          if (pi) begin
            if (m_state == 1) eih = 1'b1;
            else eim = 1'b1;
          end
          if (tk) m_phase = !m_phase;
        end
      end
      m_hm = mo;
      m_hi = in;
    end
    e = {eim, eih, (m_state != 1), (m_state != 2), (m_state == 2) && m_phase,
         (m_state == 1) && m_phase, 3'(m_sec / 10), 4'(m_sec % 10)};
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic r, input logic mo, input logic in, input logic hr);
    vec_t a, e;
    @(negedge clk);
    rst = r; bm = mo; bi = in; ih = hr;
    model(r, mo, in, hr);
    @(posedge clk);
    #1;
    cyc++;
    a = {inc_m, inc_h, en_m, en_h, blk_m, blk_h, msd, lsd};
    chk("sb_depth", exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("outs", a, e);
    end
    cnt_im   += int'(inc_m);
    cnt_ih   += int'(inc_h);
    cnt_both += int'(inc_m & inc_h);
    cnt_bm   += int'(blk_m);
    if (blk_h !== last_bh) cnt_tog++;
    last_bh = blk_h;
  endtask

  task automatic clr_cnt();
    cnt_im = 0; cnt_ih = 0; cnt_both = 0; cnt_bm = 0; cnt_tog = 0;
    last_bh = blk_h;
  endtask

  task automatic idle(input int n, input logic hr);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, hr);
  endtask

  task automatic press_modo(input logic hr);
    cycle(1'b0, 1'b1, 1'b0, hr);
    cycle(1'b0, 1'b0, 1'b0, hr);
  endtask

  task automatic press_inc(input logic hr);
    cycle(1'b0, 1'b0, 1'b1, hr);
    cycle(1'b0, 1'b0, 1'b0, hr);
  endtask

  initial begin
    // Reset
    cycle(1'b1, 1'b0, 0, 0);
    cycle(1'b1, 1'b0, 0, 0);
    chk("rst_outs", {inc_m, inc_h, en_m, en_h, blk_m, blk_h, msd, lsd}, 13'b0011_0000_00000);

    // Seconds and minute rollover
    clr_cnt();
    idle(240, 1'b0);
    chk("roll_im", cnt_im, 1);
    chk("roll_ih", cnt_ih, 0);
    chk("roll_sec", {msd, lsd}, 0);

    // Hour carry
    clr_cnt();
    idle(240, 1'b1);
    chk("carry_both", cnt_both, 1);
    chk("carry_im", cnt_im, 1);
    chk("carry_ih", cnt_ih, 1);

    // Set sequence
    idle(5, 1'b0);
    cycle(1'b0, 1'b1, 0, 0);
    chk("sh_en", {en_h, en_m}, 2'b10);
    chk("sh_sec", {msd, lsd}, 0);
    cycle(1'b0, 1'b0, 0, 0);
    clr_cnt();
    for (int i = 0; i < 3; i++) press_inc(1'b0);
    chk("sh_ih_cnt", cnt_ih, 3);
    chk("sh_im_cnt", cnt_im, 0);
    press_modo(1'b1);
    chk("sm_en", {en_h, en_m}, 2'b01);
    clr_cnt();
    for (int i = 0; i < 2; i++) press_inc(1'b1);
    chk("sm_im_cnt", cnt_im, 2);
    chk("sm_ih_cnt", cnt_ih, 0);
    cycle(1'b0, 1'b1, 0, 0);
    chk("run_en", {en_h, en_m}, 2'b11);
    chk("run_sec", {msd, lsd}, 0);
    idle(4, 1'b0);
    chk("run_sec1", {msd, lsd}, 1);

    // Held button, then mode+inc collision
    press_modo(1'b0);
    press_modo(1'b0);
    clr_cnt();
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0);
    chk("held_im", cnt_im, 1);
    press_modo(1'b0);
    press_modo(1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    chk("coll_state", {en_h, en_m}, 2'b01);
    chk("coll_pulse", {inc_m, inc_h}, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Blink in SET_HOUR
    press_modo(1'b0);
    cycle(1'b0, 1'b1, 0, 0);
    chk("blk_entry", {blk_h, blk_m}, 0);
    clr_cnt();
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("blk_h_tog", cnt_tog, 4);
    chk("blk_m_hi", cnt_bm, 0);

    // Reset coinciding with an inc press
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    chk("rst_inc", {inc_m, inc_h, en_m, en_h, blk_m, blk_h, msd, lsd}, 13'b0011_0000_00000);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_run", {en_h, en_m}, 2'b11);

    // Tick at seconds 59 colliding with a mode press
    cycle(1'b1, 1'b0, 0, 0);
    idle(239, 1'b1);
    chk("pre59", {msd, lsd}, 7'h59);
    clr_cnt();
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    chk("tk_mode_im", cnt_im, 0);
    chk("tk_mode_st", {en_h, en_m, msd, lsd}, {2'b10, 7'h00});
    cycle(1'b0, 1'b0, 0, 0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ctrl_relogio.md
Name: ctrl_relogio

Overview:
- Central controller for the digital clock: divides the system clock into a 1 Hz tick, keeps the seconds count, and drives the enable/increment inputs of the minute and hour counters.
- Runs a mode FSM (RUN / SET_HOUR / SET_MIN) driven by two pushbuttons, so the user can set the time.
- Sits between the button synchronisers and the minute/hour counters; also supplies blink flags to the display driver.

Parameters:
- DIV, 50_000_000, system clock cycles per 1 Hz tick (minimum 2).

Ports:
- ctrl_clock  in  1  system clock; all state updates on its rising edge.
- ctrl_reset  in  1  synchronous reset, active-high.
- ctrl_btn_modo  in  1  mode button, already synchronised, level, high = pressed.
- ctrl_btn_inc  in  1  increment button, already synchronised, level, high = pressed.
- ctrl_incrementa_hora  in  1  minute-counter carry flag; high while minutes read 59.
- ctrl_enable_m  out  1  minute-counter enable.
- ctrl_incremento_m  out  1  minute increment pulse, one cycle wide.
- ctrl_enable_h  out  1  hour-counter enable.
- ctrl_incremento_h  out  1  hour increment pulse, one cycle wide.
- ctrl_seg_lsd  out  4  seconds units, 0-9.
- ctrl_seg_msd  out  3  seconds tens, 0-5.
- ctrl_blink_m  out  1  display blank request for the minute digits.
- ctrl_blink_h  out  1  display blank request for the hour digits.

Behaviour:
- All outputs are registered.
- Reset values:
  - State RUN; divider count 0; seconds 00.
  - ctrl_incremento_m = 0, ctrl_incremento_h = 0.
  - ctrl_enable_m = 1, ctrl_enable_h = 1.
  - ctrl_blink_m = 0, ctrl_blink_h = 0.
  - Blink phase 0; button history registers 0.
- Divider:
  - Counts 0..DIV-1 and wraps.
  - tick = (count == DIV-1), combinational internal signal.
  - Counter clears to 0 on any mode change.
- Button edges:
  - Each button has a history register.
  - press = btn & ~hist, evaluated in cycle N.
  - Any action resulting from a press is visible on outputs at cycle N+1.
  - A held button produces exactly one press.
- Mode FSM (on press of ctrl_btn_modo):
  - RUN -> SET_HOUR -> SET_MIN -> RUN.
  - Entering SET_HOUR: seconds clear to 00 at N+1.
  - Leaving SET_MIN: divider and seconds restart from 0.
- RUN:
  - On tick, seconds advance: lsd 9 -> 0 with msd+1; 59 -> 00.
  - On the tick where seconds = 59, ctrl_incremento_m = 1 for the next cycle only.
  - If ctrl_incrementa_hora = 1 in that same cycle, ctrl_incremento_h = 1 in the same output cycle.
  - ctrl_btn_inc presses are ignored.
- SET_HOUR:
  - ctrl_enable_h = 1, ctrl_enable_m = 0.
  - Each inc press gives a one-cycle ctrl_incremento_h pulse.
  - Seconds are held at 00; ticks do not advance seconds.
- SET_MIN:
  - ctrl_enable_m = 1, ctrl_enable_h = 0.
  - Each inc press gives a one-cycle ctrl_incremento_m pulse.
  - No hour increment ever, even with ctrl_incrementa_hora = 1.
  - Seconds are held at 00.
- Blink:
  - Blink phase toggles on every tick in SET modes; it is 0 in RUN.
  - ctrl_blink_h = phase in SET_HOUR, else 0.
  - ctrl_blink_m = phase in SET_MIN, else 0.
  - Phase clears on any mode change.
- Simultaneous events:
  - Mode press and inc press in the same cycle: the mode press wins and the inc press is discarded.
  - Tick and mode press in the same cycle: the mode change wins, and no seconds or minute advance occurs.
- Reset at any point, including mid-pulse, forces reset values in the next cycle.
- Increment pulses never last more than one cycle; they are never asserted while the corresponding enable is 0.

Test Plan:
- Reset with DIV=4: assert ctrl_reset for 2 cycles -> state RUN, seconds 00, both pulses 0, both enables 1, both blinks 0.
- Seconds and minute rollover, RUN, DIV=4: run 240 cycles with ctrl_incrementa_hora = 0 -> seconds step each 4 cycles through 00..59, wrap to 00, and exactly one ctrl_incremento_m pulse occurs at the 59->00 tick; ctrl_incremento_h stays 0.
- Hour carry: repeat the rollover with ctrl_incrementa_hora = 1 at the 59th tick -> ctrl_incremento_m and ctrl_incremento_h are both high in the same single cycle.
- Set sequence: press modo (enable_h = 1, enable_m = 0, seconds 00), press inc 3 times -> exactly 3 ctrl_incremento_h pulses; press modo, press inc twice with ctrl_incrementa_hora = 1 -> 2 ctrl_incremento_m pulses and 0 hour pulses; press modo -> RUN, seconds restart at 00.
- Held button and collision: hold inc 20 cycles in SET_MIN -> exactly one pulse; press modo and inc in the same cycle in SET_HOUR -> state becomes SET_MIN with no increment pulse.
- Blink and mid-operation reset: in SET_HOUR with DIV=4, ctrl_blink_h toggles every 4 cycles and ctrl_blink_m = 0; assert reset in the same cycle as an inc press -> no pulse, and state is RUN next cycle.
